mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Multi-cycle sequencing controller for the single-issue LoongArch datapath. It steps each instruction through IF, ID, EXE, MEM and WB. It also generates every register and SRAM strobe: PC, IR, ALU-out latch, MDR, regfile write and data SRAM access. A parameterised wait counter absorbs synchronous-SRAM read latency. It sits beside the datapath in the CPU top and replaces ad-hoc per-stage enables.

## Interface
- SRAM_LAT, 1, cycles from SRAM request to valid read data; legal range 1..7

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- run  in  1  fetch permission; sampled only at IF entry
- inst_is_br  in  1  b/beq/bne class (no EXE/WB); sampled in ID
- inst_is_ld  in  1  ld.w class; sampled in ID
- inst_is_st  in  1  st.w class; sampled in ID
- inst_gr_we  in  1  instruction writes GR; sampled in ID
- br_taken  in  1  branch/jump resolved taken; sampled in ID
- inst_req  out  1  instruction SRAM read request
- ir_we  out  1  latch inst_sram_rdata into IR
- alu_we  out  1  latch ALU result
- data_req  out  1  data SRAM access
- data_we  out  1  data SRAM write (store)
- mdr_we  out  1  latch data_sram_rdata into MDR
- rf_we  out  1  regfile write strobe
- pc_we  out  1  update PC
- pc_sel_br  out  1  1: PC <- branch target; 0: PC <- PC+4
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  current state, for debug
- perf_cycle  out  32  cycle counter (see Configuration)
- perf_instret  out  32  retired-instruction counter (see Configuration)

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Encodings 5..7 go to IF on the next cycle.
- wcnt is the latency counter. It clears on every state change.
- IF:
  - wcnt==0 with run=0: hold in IF, all strobes low.
  - wcnt==0 with run=1: inst_req=1.
  - wcnt increments each cycle.
  - At wcnt==SRAM_LAT: ir_we=1, next state ID.
- ID:
  - Latch the class inputs and br_taken into internal registers.
  - inst_is_br=1: retire=1, pc_we=1, pc_sel_br=br_taken, next IF.
  - Otherwise: next EXE.
- EXE:
  - alu_we=1.
  - Latched ld or st: next MEM.
  - Otherwise: next WB.
- MEM, store:
  - data_req=1 and data_we=1 for one cycle.
  - retire=1, pc_we=1, pc_sel_br=0, next IF.
- MEM, load:
  - data_req=1 at wcnt==0.
  - mdr_we=1 at wcnt==SRAM_LAT, next WB.
- WB:
  - rf_we=latched inst_gr_we.
  - retire=1, pc_we=1, pc_sel_br=latched br_taken (covers jirl/bl), next IF.
- Priority rules:
  - If the ID class inputs assert both ld and st, st wins.
  - inst_is_br overrides ld/st.
- Strobes are decoded from the registered state and wcnt, then gated with ~reset.

## Timing
- Reset values:
  - state=IF, wcnt=0, latched class and br_taken=0.
  - All strobe outputs 0.
  - perf_cycle=0, perf_instret=0.
- Reset mid-instruction: no strobe is asserted in the reset cycle. The next cycle is IF with wcnt=0. A partially executed instruction is dropped: no retire, no rf_we, no pc_we.
- CPI with SRAM_LAT=L:
  - branch: L+2
  - ALU/jirl/bl: L+4
  - store: L+4
  - load: 2L+5
- inst_req and data_req are single-cycle pulses. The datapath holds address and wdata stable until the matching ir_we/mdr_we, or through the store cycle.
- At most one of inst_req, data_req and rf_we is high in any cycle.
- Exactly one retire pulse per instruction. pc_we is coincident with retire.

## Configuration
- MC_PERF_CNT_EN defined:
  - perf_cycle increments every cycle that reset is low.
  - perf_instret increments on each retire.
  - Both wrap modulo 2^32 and clear on reset.
- MC_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are synthesised.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state encodings MC_IF..MC_WB;
  - the state width constant;
  - the SRAM_LAT legal-range bounds.
- Sub-module mc_wait_cnt:
  - $clog2(SRAM_LAT+1)-bit counter;
  - clear and enable inputs;
  - outputs a done flag at SRAM_LAT.

## Test plan
- reset held 3 cycles mid-MEM of a load, then released with run=1 -> state=IF, no mdr_we/rf_we/retire, inst_req on the first post-reset cycle.
- SRAM_LAT=1, add.w (gr_we=1) -> inst_req@c0, ir_we@c1, alu_we@c3, rf_we+retire+pc_we@c4, pc_sel_br=0.
- SRAM_LAT=3, ld.w -> IF 4 cycles, data_req@wcnt0 of MEM, mdr_we 3 cycles later, rf_we next cycle; total 11 cycles.
- beq with br_taken=1, then bne with br_taken=0 -> each retires in ID after L+2 cycles; pc_sel_br 1 then 0; alu_we never asserted.
- st.w -> data_req=data_we=1 for exactly one cycle, rf_we never asserted; run=0 afterwards -> FSM holds in IF with no inst_req for 10 cycles.
- With MC_PERF_CNT_EN, 100 mixed instructions -> perf_instret=100 and perf_cycle equals the summed CPI; with the counter preset near 2^32-1, it wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencing controller:
// state encodings, state width and legal SRAM latency bounds.
package mc_ctrl_pkg;

  localparam int unsigned MC_STATE_W      = 3;
  localparam int unsigned MC_SRAM_LAT_MIN = 1;
  localparam int unsigned MC_SRAM_LAT_MAX = 7;

  typedef enum logic [MC_STATE_W-1:0] {
    MC_IF  = 3'd0,
    MC_ID  = 3'd1,
    MC_EXE = 3'd2,
    MC_MEM = 3'd3,
    MC_WB  = 3'd4
  } mc_state_e;

  function automatic int unsigned mc_clamp_lat(input int unsigned lat);
    if (lat < MC_SRAM_LAT_MIN) return MC_SRAM_LAT_MIN;
    if (lat > MC_SRAM_LAT_MAX) return MC_SRAM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_cnt.sv
// SRAM latency wait counter: clear has priority over enable,
// done flags the cycle the count reaches the configured latency.
module mc_wait_cnt #(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic zero_o,
  output logic done_o
);

  localparam int unsigned W = $clog2(SRAM_LAT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign done_o = (cnt_q == W'(SRAM_LAT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// IF/ID/EXE/MEM/WB sequencing controller with per-stage strobes.
// Optional perf counters enabled by defining MC_PERF_CNT_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        inst_is_br,
  input  logic        inst_is_ld,
  input  logic        inst_is_st,
  input  logic        inst_gr_we,
  input  logic        br_taken,
  output logic        inst_req,
  output logic        ir_we,
  output logic        alu_we,
  output logic        data_req,
  output logic        data_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel_br,
  output logic        retire,
  output logic [2:0]  state,
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_instret
);

  localparam int unsigned LAT = mc_clamp_lat(SRAM_LAT);

  mc_state_e state_q, state_d;
  logic ld_q, ld_d;
  logic st_q, st_d;
  logic gr_q, gr_d;
  logic tk_q, tk_d;

  logic w_zero, w_done, w_clr, w_en;

  logic ireq_c, irwe_c, aluwe_c, dreq_c, dwe_c;
  logic mdrwe_c, rfwe_c, pcwe_c, psel_c, ret_c;

  mc_wait_cnt #(
    .SRAM_LAT (LAT)
  ) u_wcnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (w_clr),
    .en_i   (w_en),
    .zero_o (w_zero),
    .done_o (w_done)
  );

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    st_d    = st_q;
    gr_d    = gr_q;
    tk_d    = tk_q;
    w_en    = 1'b0;
    ireq_c  = 1'b0;
    irwe_c  = 1'b0;
    aluwe_c = 1'b0;
    dreq_c  = 1'b0;
    dwe_c   = 1'b0;
    mdrwe_c = 1'b0;
    rfwe_c  = 1'b0;
    pcwe_c  = 1'b0;
    psel_c  = 1'b0;
    ret_c   = 1'b0;
    unique case (state_q)
      MC_IF: begin
        // run only gates the start of a fetch
        if (!w_zero || run) begin
          w_en   = 1'b1;
          ireq_c = w_zero;
          if (w_done) begin
            irwe_c  = 1'b1;
            state_d = MC_ID;
          end
        end
      end
      MC_ID: begin
        st_d = inst_is_st & ~inst_is_br;
        ld_d = inst_is_ld & ~inst_is_st & ~inst_is_br;
        gr_d = inst_gr_we;
        tk_d = br_taken;
        if (inst_is_br) begin
          ret_c   = 1'b1;
          pcwe_c  = 1'b1;
          psel_c  = br_taken;
          state_d = MC_IF;
        end else begin
          state_d = MC_EXE;
        end
      end
      MC_EXE: begin
        aluwe_c = 1'b1;
        state_d = (ld_q | st_q) ? MC_MEM : MC_WB;
      end
      MC_MEM: begin
        if (st_q) begin
          dreq_c  = 1'b1;
          dwe_c   = 1'b1;
          ret_c   = 1'b1;
          pcwe_c  = 1'b1;
          state_d = MC_IF;
        end else begin
          w_en   = 1'b1;
          dreq_c = w_zero;
          if (w_done) begin
            mdrwe_c = 1'b1;
            state_d = MC_WB;
          end
        end
      end
      MC_WB: begin
        rfwe_c  = gr_q;
        ret_c   = 1'b1;
        pcwe_c  = 1'b1;
        psel_c  = tk_q;
        state_d = MC_IF;
      end
      default: state_d = MC_IF;
    endcase
  end

  assign w_clr = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IF;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      gr_q    <= 1'b0;
      tk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      gr_q    <= gr_d;
      tk_q    <= tk_d;
    end
  end

  assign inst_req  = ireq_c  & ~reset;
  assign ir_we     = irwe_c  & ~reset;
  assign alu_we    = aluwe_c & ~reset;
  assign data_req  = dreq_c  & ~reset;
  assign data_we   = dwe_c   & ~reset;
  assign mdr_we    = mdrwe_c & ~reset;
  assign rf_we     = rfwe_c  & ~reset;
  assign pc_we     = pcwe_c  & ~reset;
  assign pc_sel_br = psel_c  & ~reset;
  assign retire    = ret_c   & ~reset;
  assign state     = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (ret_c) ret_q <= ret_q + 32'd1;
    end
  end

  assign perf_cycle   = cyc_q;
  assign perf_instret = ret_q;
`else
  assign perf_cycle   = '0;
  assign perf_instret = '0;
`endif

endmodule
